procesador_filtros: RTL and testbench

PROCESADOR_FILTROS -- requirements
Module: procesador_filtros

---
 rtl/procesador_filtros_pkg.sv | 16 +
 rtl/pf_filter_alu.sv | 34 +++
 rtl/procesador_filtros.sv | 106 ++++++++++
 tb/tb_procesador_filtros.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/procesador_filtros_pkg.sv
// procesador_filtros_pkg: FSM states, filter mode codes and status word (R) field offsets.
package procesador_filtros_pkg;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, WRITE, DONE} state_e;

    localparam logic [1:0] MODE_COPY    = 2'd0;
    localparam logic [1:0] MODE_INVERT  = 2'd1;
    localparam logic [1:0] MODE_BLUR    = 2'd2;
    localparam logic [1:0] MODE_SHARPEN = 2'd3;

    localparam int R_IDX_LSB  = 0;
    localparam int R_ADDR_LSB = 32;
    localparam int R_RES_LSB  = 64;
    localparam int R_DONE_BIT = 72;

endpackage

// File: rtl/pf_filter_alu.sv
// pf_filter_alu: combinational pixel filter over a 3-sample window (p0 newest).
// Sharpen is present only when PROCESADOR_FILTROS_SHARPEN_EN is defined; otherwise mode 3 copies.
module pf_filter_alu
    import procesador_filtros_pkg::*;
(
    input  logic [7:0] p0,
    input  logic [7:0] p1,
    input  logic [7:0] p2,
    input  logic [1:0] mode,
    output logic [7:0] result
);

    logic [9:0] blur_sum;
    assign blur_sum = {2'b00, p2} + {1'b0, p1, 1'b0} + {2'b00, p0};

`ifdef PROCESADOR_FILTROS_SHARPEN_EN
    logic signed [10:0] sharp;
    logic        [7:0]  sharp_clamp;
    assign sharp = 11'sd3 * $signed({3'b000, p0}) - $signed({3'b000, p1}) - $signed({3'b000, p2});
    // Negative saturates to 0, anything above 255 saturates to 255
    assign sharp_clamp = sharp[10] ? 8'd0 : (|sharp[9:8] ? 8'd255 : sharp[7:0]);
    always_comb begin
        result = mode == MODE_INVERT  ? ~p0 :
                 mode == MODE_BLUR    ? blur_sum[9:2] :
                 mode == MODE_SHARPEN ? sharp_clamp : p0;
    end
`else
    always_comb begin
        result = mode == MODE_INVERT ? ~p0 :
                 mode == MODE_BLUR   ? blur_sum[9:2] : p0;
    end
`endif

endmodule

// File: rtl/procesador_filtros.sv
// procesador_filtros: streams NUM_PIXELS bytes from SRC_BASE through a filter to DST_BASE, 3 cycles/pixel.
// Optional sharpen filter (MODE 3) enabled by defining PROCESADOR_FILTROS_SHARPEN_EN.
module procesador_filtros
    import procesador_filtros_pkg::*;
#(
    parameter logic [31:0] SRC_BASE   = 32'h0000_0000,
    parameter logic [31:0] DST_BASE   = 32'h0001_0000,
    parameter logic [31:0] NUM_PIXELS = 32'd65536,
    parameter int          MODE       = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  Data_in_RAM,
    output logic        mem_RE_RAM,
    output logic        mem_WE_RAM,
    output logic [31:0] Data_Dir_RAM,
    output logic [7:0]  Data_RAM,
    output logic [95:0] R
);

    localparam logic [1:0] MODE_SEL = MODE[1:0];

    state_e      state_q, state_d;
    logic [31:0] i_q, i_d;
    logic [7:0]  p0_q, p1_q, p2_q, p0_d, p1_d, p2_d;
    logic        re_q, re_d, we_q, we_d;
    logic [31:0] addr_q, addr_d, last_addr_q, last_addr_d;
    logic [7:0]  data_q, data_d, last_res_q, last_res_d;
    logic        done_q, done_d;
    logic        last_pix;
    logic [7:0]  filt;

    assign last_pix = ({1'b0, i_q} + 33'd1) >= {1'b0, NUM_PIXELS};

    pf_filter_alu u_alu (
        .p0     (p0_d),
        .p1     (p1_d),
        .p2     (p2_d),
        .mode   (MODE_SEL),
        .result (filt)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = NUM_PIXELS == 32'd0 ? DONE : FETCH;
            FETCH:   state_d = CAPTURE;
            CAPTURE: state_d = WRITE;
            WRITE:   state_d = last_pix ? DONE : FETCH;
            default: state_d = DONE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_comb begin
        i_d         = state_q == WRITE ? i_q + 32'd1 : i_q;
        p0_d        = state_q == CAPTURE ? Data_in_RAM : p0_q;
        p1_d        = state_q == CAPTURE ? p0_q : p1_q;
        p2_d        = state_q == CAPTURE ? p1_q : p2_q;
        re_d        = state_d == FETCH;
        we_d        = state_d == WRITE;
        addr_d      = state_d == FETCH ? SRC_BASE + i_d :
                      state_d == WRITE ? DST_BASE + i_d : 32'd0;
        data_d      = state_d == WRITE ? filt : 8'd0;
        last_addr_d = state_d == WRITE ? addr_d : last_addr_q;
        last_res_d  = state_d == WRITE ? filt : last_res_q;
        done_d      = state_d == DONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            i_q         <= '0;
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            re_q        <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            last_addr_q <= '0;
            last_res_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            i_q         <= i_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            p2_q        <= p2_d;
            re_q        <= re_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            last_addr_q <= last_addr_d;
            last_res_q  <= last_res_d;
            done_q      <= done_d;
        end
    end

    assign mem_RE_RAM   = re_q;
    assign mem_WE_RAM   = we_q;
    assign Data_Dir_RAM = addr_q;
    assign Data_RAM     = data_q;
    assign R            = {23'd0, done_q, last_res_q, last_addr_q, i_q};

endmodule

// File: tb/tb_procesador_filtros.sv
// tb_procesador_filtros: six parameterised instances (copy, invert, blur, sharpen, empty, mid-run reset)
// sharing one clock, each with its own source RAM; writes are checked against a scoreboard queue.
module tb_procesador_filtros;

    typedef struct {
        int          inst;
        logic [7:0]  src;
        logic [7:0]  exp;
    } row_t;

    typedef struct {
        int          inst;
        logic [31:0] addr;
        logic [7:0]  data;
    } wr_t;

    localparam logic [5:0][31:0] SB = {32'h100, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFF_FFFE};
    localparam logic [5:0][31:0] DB = {32'h200, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
                                       32'h0001_0000, 32'hFFFF_FFFF};
    localparam logic [5:0][31:0] NP = {32'd4, 32'd0, 32'd5, 32'd4, 32'd3, 32'd4};
    localparam logic [5:0][1:0]  MD = {2'd0, 2'd0, 2'd3, 2'd2, 2'd1, 2'd0};

    logic        clk = 1'b0;
    logic        rst [6];
    logic        re [6];
    logic        we [6];
    logic [31:0] addr [6];
    logic [7:0]  wd [6];
    logic [7:0]  rd [6];
    logic [95:0] r [6];
    logic [7:0]  src_mem [6][8];

    int   checks = 0;
    int   fails = 0;
    wr_t  sb[$];
    row_t tbl [20];
    int   cnt [6];
    logic zero_pulse = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 6; g++) begin : g_dut
        procesador_filtros #(
            .SRC_BASE   (SB[g]),
            .DST_BASE   (DB[g]),
            .NUM_PIXELS (NP[g]),
            .MODE       (int'(MD[g]))
        ) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .Data_in_RAM  (rd[g]),
            .mem_RE_RAM   (re[g]),
            .mem_WE_RAM   (we[g]),
            .Data_Dir_RAM (addr[g]),
            .Data_RAM     (wd[g]),
            .R            (r[g])
        );
    end

    // Synchronous-read source RAM, one cycle latency
    always @(posedge clk) begin
        for (int k = 0; k < 6; k++) begin
            logic [31:0] off;
            off = addr[k] - SB[k];
            if (re[k]) rd[k] <= src_mem[k][off[2:0]];
        end
    end

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic scan_writes();
        for (int k = 0; k < 6; k++) begin
            if (re[k] && we[k]) begin
                checks++;
                fails++;
                $display("FAIL re_we_overlap inst %0d", k);
            end
            if (k == 4 && (re[k] || we[k])) zero_pulse = 1'b1;
            if (we[k]) begin
                int idx;
                idx = -1;
                for (int j = 0; j < sb.size(); j++)
                    if (idx < 0 && sb[j].inst == k) idx = j;
                checks++;
                if (idx < 0) begin
                    fails++;
                    $display("FAIL unexpected_write inst %0d: got addr %0h data %0h expected none", k, addr[k], wd[k]);
                end else begin
                    if (addr[k] !== sb[idx].addr || wd[k] !== sb[idx].data) begin
                        fails++;
                        $display("FAIL write inst %0d: got addr %0h data %0h expected addr %0h data %0h",
                                 k, addr[k], wd[k], sb[idx].addr, sb[idx].data);
                    end
                    sb.delete(idx);
                end
            end
        end
    endtask

    initial begin
        for (int k = 0; k < 6; k++) begin
            rst[k] = 1'b1;
            cnt[k] = 0;
            for (int j = 0; j < 8; j++) src_mem[k][j] = 8'd0;
        end
        tbl[0]  = '{0, 8'd10, 8'd10};
        tbl[1]  = '{0, 8'd20, 8'd20};
        tbl[2]  = '{0, 8'd30, 8'd30};
        tbl[3]  = '{0, 8'd40, 8'd40};
        tbl[4]  = '{1, 8'h00, 8'hFF};
        tbl[5]  = '{1, 8'hFF, 8'h00};
        tbl[6]  = '{1, 8'h5A, 8'hA5};
        tbl[7]  = '{2, 8'd4,  8'd1};
        tbl[8]  = '{2, 8'd8,  8'd4};
        tbl[9]  = '{2, 8'd12, 8'd8};
        tbl[10] = '{2, 8'd16, 8'd12};
`ifdef PROCESADOR_FILTROS_SHARPEN_EN
        tbl[11] = '{3, 8'd10,  8'd30};
        tbl[12] = '{3, 8'd20,  8'd50};
        tbl[13] = '{3, 8'd30,  8'd60};
        tbl[14] = '{3, 8'd255, 8'd255};
        tbl[15] = '{3, 8'd0,   8'd0};
`else
        tbl[11] = '{3, 8'd10,  8'd10};
        tbl[12] = '{3, 8'd20,  8'd20};
        tbl[13] = '{3, 8'd30,  8'd30};
        tbl[14] = '{3, 8'd255, 8'd255};
        tbl[15] = '{3, 8'd0,   8'd0};
`endif
        tbl[16] = '{5, 8'd1, 8'd1};
        tbl[17] = '{5, 8'd2, 8'd2};
        tbl[18] = '{5, 8'd3, 8'd3};
        tbl[19] = '{5, 8'd4, 8'd4};
        // Pixels 0 and 1 of the reset instance are written before the abort, then all four again
        sb.push_back('{5, 32'h200, 8'd1});
        sb.push_back('{5, 32'h201, 8'd2});
        for (int j = 0; j < 20; j++) begin
            int k;
            k = tbl[j].inst;
            src_mem[k][cnt[k]] = tbl[j].src;
            sb.push_back('{k, DB[k] + 32'(cnt[k]), tbl[j].exp});
            cnt[k]++;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 6; k++)
            chk($sformatf("reset_state_%0d", k), {r[k], re[k], we[k], addr[k], wd[k]}, '0);
        for (int k = 0; k < 6; k++) rst[k] = 1'b0;
        for (int e = 1; e <= 45; e++) begin
            @(posedge clk);
            @(negedge clk);
            scan_writes();
            if (e == 1) begin
                chk("copy_first_fetch", {re[0], addr[0]}, {1'b1, 32'hFFFF_FFFE});
                chk("empty_done", 96'(r[4][72]), 96'd1);
            end
            if (e == 8) rst[5] = 1'b1;
            if (e == 9) begin
                chk("abort_no_write", {re[5], we[5], addr[5], wd[5]}, '0);
                chk("abort_r_cleared", r[5], '0);
                rst[5] = 1'b0;
            end
            if (e == 10) chk("restart_fetch", {re[5], addr[5]}, {1'b1, 32'h100});
            if (e == 12) chk("copy_not_done_12", 96'(r[0][72]), 96'd0);
            if (e == 13) chk("copy_done_13", 96'(r[0][72]), 96'd1);
        end
        chk("scoreboard_empty", 96'(sb.size()), 96'd0);
        chk("empty_no_pulse", 96'(zero_pulse), 96'd0);
        chk("copy_status", r[0], {23'd0, 1'b1, 8'd40, 32'h2, 32'd4});
        chk("invert_status", r[1], {23'd0, 1'b1, 8'hA5, 32'h0001_0002, 32'd3});
        chk("reset_inst_status", r[5], {23'd0, 1'b1, 8'd4, 32'h203, 32'd4});
        for (int k = 2; k < 4; k++) chk($sformatf("done_%0d", k), 96'(r[k][72]), 96'd1);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
